// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog controller: FSM states, register map and CTRL layout.
package wdt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_WARN  = 2'd2,
      ST_RESET = 2'd3
   } wdt_state_e;

   localparam logic [7:0] OFS_CTRL = 8'h00;
   localparam logic [7:0] OFS_LOAD = 8'h04;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_RST_EN = 2;
   localparam int CTRL_PRESC  = 8;
   localparam int CTRL_TOF    = 31;
   localparam int PRESC_W     = 8;

endpackage

// File: rtl/wdt_ctrl_if.sv
// Register access bus of the watchdog: per-register access strobes, write data, read data.
interface wdt_ctrl_if;
   logic        ena00;
   logic        ena04;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] dataout;

   modport master (output ena00, ena04, pwrite, pwdata, input dataout);
   modport slave  (input ena00, ena04, pwrite, pwdata, output dataout);
endinterface

// File: rtl/wdt_prescaler.sv
// Tick divider: one tick every presc+1 cycles while run is high. Built only with WDT_PRESCALER_EN.
`ifdef WDT_PRESCALER_EN
module wdt_prescaler import wdt_pkg::*; (
   input  logic               pclk,
   input  logic               rst,
   input  logic               run,
   input  logic               restart,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);
   logic [PRESC_W-1:0] pcnt;

   // >= so that lowering PRESC mid-period ticks at once instead of wrapping
   assign tick = run & (pcnt >= presc);

   always_ff @(posedge pclk or posedge rst) begin
      if (rst)                         pcnt <= '0;
      else if (!run || restart || tick) pcnt <= '0;
      else                             pcnt <= pcnt + 1'b1;
   end
endmodule
`endif

// File: rtl/wdt_ctrl.sv
// Watchdog controller: CTRL/LOAD registers, IDLE/COUNT/WARN/RESET FSM, irq and reset-request outputs.
// Optional prescaler field CTRL[15:8] is present only when WDT_PRESCALER_EN is defined.
module wdt_ctrl import wdt_pkg::*; #(
   parameter int CNT_W   = 32,
   parameter int RST_CYC = 16
) (
   input  logic       pclk,
   input  logic       rst,
   wdt_ctrl_if.slave  bus,
   output logic       wdt_irq,
   output logic       wdt_rst
);
   localparam int              RC_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);

   wdt_state_e       state, state_n;
   logic             en, en_n, irq_en, irq_en_n, rst_en, rst_en_n, tof, tof_n;
   logic [CNT_W-1:0] load, load_n, cnt, cnt_n;
   logic [RC_W-1:0]  rc, rc_n;
   logic             running, wr_ctrl, kick, tick;

   assign running = (state == ST_COUNT) || (state == ST_WARN);
   assign wr_ctrl = bus.ena00 & bus.pwrite & (state != ST_RESET);
   assign kick    = bus.ena04 & bus.pwrite & (state != ST_RESET);

`ifdef WDT_PRESCALER_EN
   logic [PRESC_W-1:0] presc, presc_n;

   wdt_prescaler u_presc (
      .pclk    (pclk),
      .rst     (rst),
      .run     (running),
      .restart (kick),
      .presc   (presc),
      .tick    (tick)
   );

   always_comb begin
      presc_n = presc;
      if (wr_ctrl) presc_n = bus.pwdata[CTRL_PRESC +: PRESC_W];
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) presc <= '0;
      else     presc <= presc_n;
   end
`else
   assign tick = running;
`endif

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         en      <= 1'b0;
         irq_en  <= 1'b0;
         rst_en  <= 1'b0;
         tof     <= 1'b0;
         load    <= '1;
         cnt     <= '1;
         rc      <= '0;
         wdt_irq <= 1'b0;
         wdt_rst <= 1'b0;
      end else begin
         state   <= state_n;
         en      <= en_n;
         irq_en  <= irq_en_n;
         rst_en  <= rst_en_n;
         tof     <= tof_n;
         load    <= load_n;
         cnt     <= cnt_n;
         rc      <= rc_n;
         // outputs come straight from flops, fed by next-state values
         wdt_irq <= tof_n & irq_en_n;
         wdt_rst <= (state_n == ST_RESET);
      end
   end

   always_comb begin
      state_n  = state;
      en_n     = en;
      irq_en_n = irq_en;
      rst_en_n = rst_en;
      tof_n    = tof;
      load_n   = load;
      cnt_n    = cnt;
      rc_n     = rc;

      if (wr_ctrl) begin
         en_n     = bus.pwdata[CTRL_EN];
         irq_en_n = bus.pwdata[CTRL_IRQ_EN];
         rst_en_n = bus.pwdata[CTRL_RST_EN];
      end
      if (kick) load_n = bus.pwdata[CNT_W-1:0];

      case (state)
         ST_IDLE: begin
            cnt_n = load_n;
            rc_n  = '0;
            if (en) state_n = ST_COUNT;
         end
         ST_COUNT, ST_WARN: begin
            // disable beats kick, kick beats an expiring tick
            if (wr_ctrl && !bus.pwdata[CTRL_EN]) begin
               state_n = ST_IDLE;
               tof_n   = 1'b0;
               cnt_n   = load;
            end else if (kick) begin
               state_n = ST_COUNT;
               tof_n   = 1'b0;
               cnt_n   = load_n;
            end else if (tick) begin
               if (cnt == '0) begin
                  cnt_n = load;
                  if (state == ST_COUNT) begin
                     state_n = ST_WARN;
                     tof_n   = 1'b1;
                  end else if (rst_en) begin
                     state_n = ST_RESET;
                     rc_n    = '0;
                  end else begin
                     state_n = ST_COUNT;
                  end
               end else begin
                  cnt_n = cnt - 1'b1;
               end
            end
         end
         ST_RESET: begin
            if (rc == RC_LAST) begin
               state_n = ST_IDLE;
               en_n    = 1'b0;
            end else begin
               rc_n = rc + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.dataout = '0;
      if (bus.ena00) begin
         bus.dataout[CTRL_EN]     = en;
         bus.dataout[CTRL_IRQ_EN] = irq_en;
         bus.dataout[CTRL_RST_EN] = rst_en;
         bus.dataout[CTRL_TOF]    = tof;
`ifdef WDT_PRESCALER_EN
         bus.dataout[CTRL_PRESC +: PRESC_W] = presc;
`endif
      end else if (bus.ena04) begin
         bus.dataout[CNT_W-1:0] = cnt;
      end
   end

endmodule
